instruction_cache: RTL and testbench

- Direct-mapped, read-only instruction cache that answers the CPU's fetch requests (PC in, INSTRUCTION out, BUSYWAIT back to the CPU).
- On a miss it acts as initiator on a block-read interface to the instruction memory, which uses the same busywait handshake as the data-side memory.
- Sits between the CPU's PC/INSTRUCTION ports and a 1024-byte instruction memory.
- Geometry: 8 blocks x 16 bytes, i.e. 4 instructions per block.

---
 rtl/instruction_cache_if.sv | 21 ++
 rtl/instruction_cache.sv | 142 ++++++++++++++
 tb/tb_instruction_cache.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// CPU fetch port and instruction-memory block-read port of instruction_cache.
// The cache takes the slave side; the CPU/memory environment takes the master side.
interface instruction_cache_if;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport slave (
        input  PC, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport master (
        output PC, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, 8 blocks x 16 bytes, fill over a busywait block bus.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instruction_cache (
    input  logic                CLK,
    input  logic                RESET,
    instruction_cache_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]         HIT_COUNT,
    output logic [15:0]         MISS_COUNT
`endif
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_READ = 2'd1;
    localparam logic [1:0] S_UPDATE   = 2'd2;

    logic [1:0]   state_r;
    logic         first_r;
    logic [7:0]   valid_r;
    logic [2:0]   tag_r  [8];
    logic [127:0] data_r [8];
    logic [5:0]   fill_addr_r;
    logic [127:0] fill_data_r;

    logic [2:0]   pc_tag_s;
    logic [2:0]   pc_index_s;
    logic [1:0]   pc_offset_s;
    logic         hit_s;
    logic [31:0]  word_s;
    logic         busywait_s;
    logic [31:0]  instr_s;

    assign pc_tag_s    = bus.PC[9:7];
    assign pc_index_s  = bus.PC[6:4];
    assign pc_offset_s = bus.PC[3:2];
    assign hit_s       = valid_r[pc_index_s] && (tag_r[pc_index_s] == pc_tag_s);

    // Word select within the addressed block
    always_comb begin
        word_s = 32'h0;
        case (pc_offset_s)
            2'd0:    word_s = data_r[pc_index_s][31:0];
            2'd1:    word_s = data_r[pc_index_s][63:32];
            2'd2:    word_s = data_r[pc_index_s][95:64];
            2'd3:    word_s = data_r[pc_index_s][127:96];
            default: word_s = 32'h0;
        endcase
    end

    // CPU-side outputs; a hit in IDLE answers in the same cycle, reset forces the idle values
    always_comb begin
        busywait_s = 1'b0;
        instr_s    = 32'h0;
        if (RESET) begin
            busywait_s = 1'b0;
            instr_s    = 32'h0;
        end else if ((state_r == S_IDLE) && hit_s) begin
            busywait_s = 1'b0;
            instr_s    = word_s;
        end else begin
            busywait_s = 1'b1;
            instr_s    = 32'h0;
        end
    end

    assign bus.BUSYWAIT    = busywait_s;
    assign bus.INSTRUCTION = instr_s;
    assign bus.MEM_READ    = (state_r == S_MEM_READ);
    assign bus.MEM_ADDRESS = fill_addr_r;

    // Miss-handling FSM and valid bits; the fill address is frozen on entry to MEM_READ
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= S_IDLE;
            first_r     <= 1'b0;
            valid_r     <= 8'h00;
            fill_addr_r <= 6'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!hit_s) begin
                        state_r     <= S_MEM_READ;
                        first_r     <= 1'b1;
                        fill_addr_r <= {pc_tag_s, pc_index_s};
                    end
                end
                S_MEM_READ: begin
                    if (first_r) begin
                        first_r <= 1'b0;
                    end else if (!bus.MEM_BUSYWAIT) begin
                        state_r <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    valid_r[fill_addr_r[2:0]] <= 1'b1;
                    state_r                   <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Block capture and array write; tag and data storage carry no reset
    always_ff @(posedge CLK) begin
        if ((state_r == S_MEM_READ) && !first_r && !bus.MEM_BUSYWAIT) begin
            fill_data_r <= bus.MEM_READDATA;
        end
        if (state_r == S_UPDATE) begin
            tag_r[fill_addr_r[2:0]]  <= fill_addr_r[5:3];
            data_r[fill_addr_r[2:0]] <= fill_data_r;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] last_pc_r;

    // Saturating statistics; a missed PC is remembered so its post-fill hit is not counted again
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            HIT_COUNT  <= 16'h0000;
            MISS_COUNT <= 16'h0000;
            last_pc_r  <= 32'h0000_0000;
        end else if (state_r == S_IDLE) begin
            if (!hit_s) begin
                last_pc_r <= bus.PC;
                if (MISS_COUNT != 16'hFFFF) begin
                    MISS_COUNT <= MISS_COUNT + 16'd1;
                end
            end else if (bus.PC != last_pc_r) begin
                last_pc_r <= bus.PC;
                if (HIT_COUNT != 16'hFFFF) begin
                    HIT_COUNT <= HIT_COUNT + 16'd1;
                end
            end else begin
                last_pc_r <= last_pc_r;
            end
        end else begin
            last_pc_r <= last_pc_r;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a 5-cycle busywait memory model.
module tb_instruction_cache;
    logic CLK;
    logic RESET;
    int   checks;
    int   fails;
    int   mem_cnt;

    instruction_cache_if bus();

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    instruction_cache dut (.CLK(CLK), .RESET(RESET), .bus(bus),
                           .HIT_COUNT(hit_count), .MISS_COUNT(miss_count));
`else
    instruction_cache dut (.CLK(CLK), .RESET(RESET), .bus(bus));
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents: block 0 holds 0x11111111..0x44444444, other blocks are tagged by address
    function automatic logic [31:0] exp_word(input logic [5:0] a, input int w);
        logic [31:0] base;
        base = {8{4'(w + 1)}};
        return base ^ {18'h0, a, 8'h00};
    endfunction

    always @(posedge CLK) begin
        if (!bus.MEM_READ) mem_cnt <= 0;
        else               mem_cnt <= mem_cnt + 1;
    end
    assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt < 5);
    assign bus.MEM_READDATA = {exp_word(bus.MEM_ADDRESS, 3), exp_word(bus.MEM_ADDRESS, 2),
                               exp_word(bus.MEM_ADDRESS, 1), exp_word(bus.MEM_ADDRESS, 0)};

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.BUSYWAIT === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_memread(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.MEM_READ === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RESET  = 1'b1;
        bus.PC = 32'h0;
        repeat (2) @(negedge CLK);
        checks++; if (bus.BUSYWAIT !== 1'b0) begin fails++; $display("FAIL reset_busywait got %b want 0", bus.BUSYWAIT); end
        checks++; if (bus.INSTRUCTION !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", bus.INSTRUCTION); end
        checks++; if (bus.MEM_READ !== 1'b0) begin fails++; $display("FAIL reset_mem_read got %b want 0", bus.MEM_READ); end
        checks++; if (bus.MEM_ADDRESS !== 6'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", bus.MEM_ADDRESS); end
    endtask

    task automatic test_cold_miss;
        bit ok;
        bus.PC = 32'h0;
        RESET  = 1'b0;
        #1;
        checks++; if (bus.BUSYWAIT !== 1'b1) begin fails++; $display("FAIL cold_busywait got %b want 1", bus.BUSYWAIT); end
        @(negedge CLK);
        checks++; if (bus.MEM_READ !== 1'b1) begin fails++; $display("FAIL cold_mem_read got %b want 1", bus.MEM_READ); end
        checks++; if (bus.MEM_ADDRESS !== 6'd0) begin fails++; $display("FAIL cold_mem_addr got %0d want 0", bus.MEM_ADDRESS); end
        wait_ready(ok);
        checks++; if (!ok) begin fails++; $display("FAIL cold_fill_timeout busywait stuck at %b want 0", bus.BUSYWAIT); end
        checks++; if (bus.INSTRUCTION !== 32'h11111111) begin fails++; $display("FAIL cold_instr got %h want 11111111", bus.INSTRUCTION); end
    endtask

    task automatic test_sequential;
        logic [31:0] exp [3];
        exp[0] = 32'h22222222; exp[1] = 32'h33333333; exp[2] = 32'h44444444;
        for (int i = 0; i < 3; i++) begin
            bus.PC = 32'(4 * (i + 1));
            #1;
            checks++; if (bus.BUSYWAIT !== 1'b0 || bus.MEM_READ !== 1'b0) begin fails++; $display("FAIL seq_stall pc=%h got busy=%b mem_read=%b want 0/0", bus.PC, bus.BUSYWAIT, bus.MEM_READ); end
            checks++; if (bus.INSTRUCTION !== exp[i]) begin fails++; $display("FAIL seq_instr pc=%h got %h want %h", bus.PC, bus.INSTRUCTION, exp[i]); end
            @(negedge CLK);
        end
    endtask

    task automatic test_conflict;
        bit ok;
        bus.PC = 32'h080;
        @(negedge CLK);
        checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDRESS !== 6'd8) begin fails++; $display("FAIL conflict_addr1 got rd=%b addr=%0d want 1/8", bus.MEM_READ, bus.MEM_ADDRESS); end
        wait_ready(ok);
        checks++; if (!ok || bus.INSTRUCTION !== exp_word(6'd8, 0)) begin fails++; $display("FAIL conflict_instr1 got %h want %h", bus.INSTRUCTION, exp_word(6'd8, 0)); end
        bus.PC = 32'h0;
        #1;
        checks++; if (bus.BUSYWAIT !== 1'b1) begin fails++; $display("FAIL conflict_evict got busy=%b want 1", bus.BUSYWAIT); end
        @(negedge CLK);
        checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDRESS !== 6'd0) begin fails++; $display("FAIL conflict_addr2 got rd=%b addr=%0d want 1/0", bus.MEM_READ, bus.MEM_ADDRESS); end
        wait_ready(ok);
        checks++; if (!ok || bus.INSTRUCTION !== 32'h11111111) begin fails++; $display("FAIL conflict_instr2 got %h want 11111111", bus.INSTRUCTION); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bus.PC = 32'h3F0;
        @(negedge CLK);
        checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDRESS !== 6'd63) begin fails++; $display("FAIL rstmid_start got rd=%b addr=%0d want 1/63", bus.MEM_READ, bus.MEM_ADDRESS); end
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        checks++; if (bus.MEM_READ !== 1'b0 || bus.BUSYWAIT !== 1'b0) begin fails++; $display("FAIL rstmid_async got rd=%b busy=%b want 0/0", bus.MEM_READ, bus.BUSYWAIT); end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++; if (bus.BUSYWAIT !== 1'b1) begin fails++; $display("FAIL rstmid_remiss got busy=%b want 1", bus.BUSYWAIT); end
        @(negedge CLK);
        checks++; if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDRESS !== 6'd63) begin fails++; $display("FAIL rstmid_addr got rd=%b addr=%0d want 1/63", bus.MEM_READ, bus.MEM_ADDRESS); end
        wait_ready(ok);
        checks++; if (!ok || bus.INSTRUCTION !== exp_word(6'd63, 0)) begin fails++; $display("FAIL rstmid_instr got %h want %h", bus.INSTRUCTION, exp_word(6'd63, 0)); end
    endtask

    task automatic test_pc_change;
        bit ok;
        bit addr_held;
        bus.PC = 32'h010;
        @(negedge CLK);
        bus.PC = 32'h020;
        addr_held = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.MEM_READ !== 1'b1) begin ok = 1'b1; break; end
            if (bus.MEM_ADDRESS !== 6'd1) addr_held = 1'b0;
            @(negedge CLK);
        end
        checks++; if (!ok || !addr_held) begin fails++; $display("FAIL pcchg_hold got done=%b held=%b want 1/1", ok, addr_held); end
        wait_memread(1'b1, ok);
        checks++; if (!ok || bus.MEM_ADDRESS !== 6'd2) begin fails++; $display("FAIL pcchg_second got rd=%b addr=%0d want 1/2", bus.MEM_READ, bus.MEM_ADDRESS); end
        wait_ready(ok);
        checks++; if (!ok || bus.INSTRUCTION !== exp_word(6'd2, 0)) begin fails++; $display("FAIL pcchg_instr got %h want %h", bus.INSTRUCTION, exp_word(6'd2, 0)); end
        bus.PC = 32'h010;
        #1;
        checks++; if (bus.BUSYWAIT !== 1'b0 || bus.INSTRUCTION !== exp_word(6'd1, 0)) begin fails++; $display("FAIL pcchg_idx1 got busy=%b instr=%h want 0/%h", bus.BUSYWAIT, bus.INSTRUCTION, exp_word(6'd1, 0)); end
        @(negedge CLK);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats;
        bit ok;
        RESET = 1'b1;
        bus.PC = 32'h0;
        @(negedge CLK);
        RESET = 1'b0;
        wait_ready(ok);
        bus.PC = 32'h4; @(negedge CLK);
        bus.PC = 32'h8; @(negedge CLK);
        bus.PC = 32'h080; wait_ready(ok);
        bus.PC = 32'h0;   wait_ready(ok);
        checks++; if (miss_count !== 16'd3) begin fails++; $display("FAIL stats_miss got %0d want 3", miss_count); end
        checks++; if (hit_count !== 16'd2) begin fails++; $display("FAIL stats_hit got %0d want 2", hit_count); end
    endtask
`endif

    initial begin
        checks = 0;
        fails  = 0;
        bus.PC = 32'h0;
        RESET  = 1'b1;
        test_reset();
        test_cold_miss();
        test_sequential();
        test_conflict();
        test_reset_mid();
        test_pc_change();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
